axis_elastic_buffer: RTL and testbench

- Parametrised successor to the two-entry AXI4-Stream skid register: a DEPTH-entry elastic buffer with full throughput, registered s_axis_tready and a registered output stage.
- Adds an occupancy count, an almost-full flag and a synchronous flush.
- Sits between CGRA stream producers and consumers where more slack than a skid register is needed, e.g. DMA-to-engine and engine-to-DMA crossings of long routing paths.

---
 rtl/axis_elastic_buffer_pkg.sv | 16 +
 rtl/axis_elastic_ram.sv | 66 ++++++
 rtl/axis_elastic_buffer.sv | 136 +++++++++++++
 tb/tb_axis_elastic_buffer.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_elastic_buffer_pkg.sv
// axis_elastic_buffer shared types and helpers.
// Pointer sizing and output-register load source.
package axis_elastic_buffer_pkg;

  typedef enum logic [1:0] {
    SRC_HOLD,
    SRC_RAM,
    SRC_BYPASS
  } out_src_e;

  // A one-entry array still needs a 1-bit pointer.
  function automatic int ptr_width(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

endpackage

// File: rtl/axis_elastic_ram.sv
// Circular storage behind the output register of axis_elastic_buffer.
// Entry count need not be a power of two; pointers wrap by compare.
module axis_elastic_ram
  import axis_elastic_buffer_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ENTRIES = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  localparam int PW = ptr_width(ENTRIES);
  localparam int UW = $clog2(ENTRIES + 1);

  logic [WIDTH-1:0] mem [ENTRIES];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [UW-1:0]    used;

  function automatic logic [PW-1:0] wrap_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(ENTRIES - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rdata = mem[rd_ptr];
  assign empty = (used == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wrap_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= wrap_inc(rd_ptr);
      end
      unique case ({push, pop})
        2'b10:   used <= used + UW'(1);
        2'b01:   used <= used - UW'(1);
        default: used <= used;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/axis_elastic_buffer.sv
// DEPTH-entry AXI4-Stream elastic buffer: registered ready/valid,
// occupancy count, almost-full flag and synchronous flush.
module axis_elastic_buffer
  import axis_elastic_buffer_pkg::*;
#(
  parameter int DATA_WIDTH        = 8,
  parameter int KEEP_ENABLE       = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH        = (DATA_WIDTH / 8),
  parameter int LAST_ENABLE       = 1,
  parameter int USER_ENABLE       = 1,
  parameter int USER_WIDTH        = 1,
  parameter int DEPTH             = 4,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]        s_axis_tkeep,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  input  logic [USER_WIDTH-1:0]        s_axis_tuser,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]        m_axis_tkeep,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [USER_WIDTH-1:0]        m_axis_tuser,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);

  localparam int ENTRIES = DEPTH - 1;
  localparam int CW      = $clog2(DEPTH + 1);
  localparam int LAST_LO = DATA_WIDTH + KEEP_WIDTH;
  localparam int USER_LO = LAST_LO + 1;
  localparam int WORD    = USER_LO + USER_WIDTH;

  logic            accept;
  logic            pop;
  logic            load;
  logic            ram_push;
  logic            ram_pop;
  logic            ram_empty;
  logic [WORD-1:0] in_word;
  logic [WORD-1:0] ram_word;
  logic [WORD-1:0] out_word;
  logic            in_ready;
  logic            out_valid;
  logic            af_q;
  logic [CW-1:0]   count_q;
  logic [CW:0]     count_next;
  out_src_e        src;

  assign accept  = s_axis_tvalid && in_ready;
  assign pop     = out_valid && m_axis_tready;
  assign load    = !out_valid || pop;
  assign in_word = {s_axis_tuser, s_axis_tlast,
                    s_axis_tkeep, s_axis_tdata};

  always_comb begin
    src = SRC_HOLD;
    unique case (1'b1)
      (load && !ram_empty):          src = SRC_RAM;
      (load && ram_empty && accept): src = SRC_BYPASS;
      default:                       src = SRC_HOLD;
    endcase
  end

  // Bypassed beats skip the array entirely.
  assign ram_pop  = (src == SRC_RAM);
  assign ram_push = accept && (src != SRC_BYPASS);

  assign count_next = {1'b0, count_q}
                    + {{CW{1'b0}}, accept}
                    - {{CW{1'b0}}, pop};

  axis_elastic_ram #(
    .WIDTH   (WORD),
    .ENTRIES (ENTRIES)
  ) u_ram (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .push  (ram_push),
    .pop   (ram_pop),
    .wdata (in_word),
    .rdata (ram_word),
    .empty (ram_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      count_q   <= '0;
      af_q      <= 1'b0;
    end else if (flush) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      count_q   <= '0;
      af_q      <= 1'b0;
    end else begin
      in_ready  <= count_next < (CW+1)'(DEPTH);
      out_valid <= (src != SRC_HOLD) || !load;
      count_q   <= count_next[CW-1:0];
      af_q      <= count_next >= (CW+1)'(ALMOST_FULL_LEVEL);
    end
  end

  always_ff @(posedge clk) begin
    if (src == SRC_RAM) begin
      out_word <= ram_word;
    end else if (src == SRC_BYPASS) begin
      out_word <= in_word;
    end
  end

  assign s_axis_tready = in_ready;
  assign m_axis_tvalid = out_valid;
  assign count         = count_q;
  assign almost_full   = af_q;
  assign m_axis_tdata  = out_word[DATA_WIDTH-1:0];

  assign m_axis_tkeep = (KEEP_ENABLE != 0)
                      ? out_word[DATA_WIDTH +: KEEP_WIDTH]
                      : '1;
  assign m_axis_tlast = (LAST_ENABLE != 0)
                      ? out_word[LAST_LO]
                      : 1'b1;
  assign m_axis_tuser = (USER_ENABLE != 0)
                      ? out_word[USER_LO +: USER_WIDTH]
                      : '0;

endmodule

// File: tb/tb_axis_elastic_buffer.sv
// Bench for axis_elastic_buffer: directed DEPTH=4 scenarios plus
// randomized DEPTH=8 / DEPTH=2 runs against a queue model.
module tb_axis_elastic_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  int   checks   = 0;
  int   failures = 0;

  logic       flush4;
  logic [7:0] s4_data;
  logic [0:0] s4_keep;
  logic       s4_valid;
  logic       s4_ready;
  logic       s4_last;
  logic [0:0] s4_user;
  logic [7:0] m4_data;
  logic [0:0] m4_keep;
  logic       m4_valid;
  logic       m4_ready;
  logic       m4_last;
  logic [0:0] m4_user;
  logic [2:0] cnt4;
  logic       af4;

  logic       r_flush  [2];
  logic [7:0] r_sdata  [2];
  logic [0:0] r_skeep  [2];
  logic       r_svalid [2];
  logic       r_sready [2];
  logic       r_slast  [2];
  logic [0:0] r_suser  [2];
  logic [7:0] r_mdata  [2];
  logic [0:0] r_mkeep  [2];
  logic       r_mvalid [2];
  logic       r_mready [2];
  logic       r_mlast  [2];
  logic [0:0] r_muser  [2];
  logic       r_af     [2];
  logic [3:0] cnt8;
  logic [1:0] cnt2;

  axis_elastic_buffer #(
    .DATA_WIDTH (8), .DEPTH (4), .ALMOST_FULL_LEVEL (3)
  ) d4 (
    .clk (clk), .rstn (rstn), .flush (flush4),
    .s_axis_tdata (s4_data), .s_axis_tkeep (s4_keep),
    .s_axis_tvalid (s4_valid), .s_axis_tready (s4_ready),
    .s_axis_tlast (s4_last), .s_axis_tuser (s4_user),
    .m_axis_tdata (m4_data), .m_axis_tkeep (m4_keep),
    .m_axis_tvalid (m4_valid), .m_axis_tready (m4_ready),
    .m_axis_tlast (m4_last), .m_axis_tuser (m4_user),
    .count (cnt4), .almost_full (af4)
  );

  axis_elastic_buffer #(
    .DATA_WIDTH (8), .DEPTH (8)
  ) d8 (
    .clk (clk), .rstn (rstn), .flush (r_flush[0]),
    .s_axis_tdata (r_sdata[0]), .s_axis_tkeep (r_skeep[0]),
    .s_axis_tvalid (r_svalid[0]), .s_axis_tready (r_sready[0]),
    .s_axis_tlast (r_slast[0]), .s_axis_tuser (r_suser[0]),
    .m_axis_tdata (r_mdata[0]), .m_axis_tkeep (r_mkeep[0]),
    .m_axis_tvalid (r_mvalid[0]), .m_axis_tready (r_mready[0]),
    .m_axis_tlast (r_mlast[0]), .m_axis_tuser (r_muser[0]),
    .count (cnt8), .almost_full (r_af[0])
  );

  axis_elastic_buffer #(
    .DATA_WIDTH (8), .DEPTH (2)
  ) d2 (
    .clk (clk), .rstn (rstn), .flush (r_flush[1]),
    .s_axis_tdata (r_sdata[1]), .s_axis_tkeep (r_skeep[1]),
    .s_axis_tvalid (r_svalid[1]), .s_axis_tready (r_sready[1]),
    .s_axis_tlast (r_slast[1]), .s_axis_tuser (r_suser[1]),
    .m_axis_tdata (r_mdata[1]), .m_axis_tkeep (r_mkeep[1]),
    .m_axis_tvalid (r_mvalid[1]), .m_axis_tready (r_mready[1]),
    .m_axis_tlast (r_mlast[1]), .m_axis_tuser (r_muser[1]),
    .count (cnt2), .almost_full (r_af[1])
  );

  task automatic drive_idle();
    flush4   = 1'b0;
    s4_data  = '0;
    s4_keep  = 1'b1;
    s4_valid = 1'b0;
    s4_last  = 1'b0;
    s4_user  = '0;
    m4_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      r_flush[k]  = 1'b0;
      r_sdata[k]  = '0;
      r_skeep[k]  = 1'b1;
      r_svalid[k] = 1'b0;
      r_slast[k]  = 1'b0;
      r_suser[k]  = '0;
      r_mready[k] = 1'b0;
    end
  endtask

  // Leaves the bench at a falling edge with ready already up.
  task automatic do_reset();
    rstn = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic push4(input logic [7:0] d);
    int g = 0;
    s4_valid = 1'b1;
    s4_data  = d;
    while (!s4_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (!s4_ready) begin
      failures++;
      $display("FAIL push4_timeout: data %h never accepted", d);
    end
    @(negedge clk);
    s4_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive_idle();
    s4_valid = 1'b1;
    s4_data  = 8'h01;
    @(negedge clk);
    checks++;
    if (s4_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready: got %b want 0", s4_ready);
    end
    checks++;
    if (m4_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid: got %b want 0", m4_valid);
    end
    checks++;
    if (cnt4 !== 3'd0) begin
      failures++; $display("FAIL reset_count: got %0d want 0", cnt4);
    end
    rstn = 1'b1;
    #1;
    checks++;
    if (s4_ready !== 1'b0) begin
      failures++; $display("FAIL release_ready_early: got %b want 0", s4_ready);
    end
    @(negedge clk);
    checks++;
    if (s4_ready !== 1'b1) begin
      failures++; $display("FAIL release_ready: got %b want 1", s4_ready);
    end
    @(negedge clk);
    checks++;
    if (m4_valid !== 1'b1 || m4_data !== 8'h01) begin
      failures++;
      $display("FAIL first_beat: got v=%b d=%h want v=1 d=01", m4_valid, m4_data);
    end
    checks++;
    if (cnt4 !== 3'd1) begin
      failures++; $display("FAIL first_count: got %0d want 1", cnt4);
    end
    s4_data = 8'h02;
    @(negedge clk);
    s4_valid = 1'b0;
    checks++;
    if (cnt4 !== 3'd2 || m4_data !== 8'h01) begin
      failures++;
      $display("FAIL second_beat: got c=%0d d=%h want c=2 d=01", cnt4, m4_data);
    end
  endtask

  task automatic test_backpressure_fill();
    int idx = 0;
    do_reset();
    m4_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (cnt4 !== 3'(idx)) begin
        failures++; $display("FAIL fill_count: got %0d want %0d", cnt4, idx);
      end
      checks++;
      if (af4 !== (idx >= 3)) begin
        failures++; $display("FAIL fill_af: got %b want %b", af4, idx >= 3);
      end
      checks++;
      if (s4_ready !== (idx < 4)) begin
        failures++; $display("FAIL fill_ready: got %b want %b", s4_ready, idx < 4);
      end
      s4_valid = (idx < 6);
      s4_data  = 8'hA0 + 8'(idx);
      if (s4_valid && s4_ready) idx++;
      @(negedge clk);
    end
    s4_valid = 1'b0;
    checks++;
    if (idx !== 4) begin
      failures++; $display("FAIL fill_accepted: got %0d want 4", idx);
    end
    m4_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (m4_valid !== 1'b1 || m4_data !== 8'hA0 + 8'(i)) begin
        failures++;
        $display("FAIL drain_%0d: got v=%b d=%h want v=1 d=%h",
                 i, m4_valid, m4_data, 8'hA0 + 8'(i));
      end
      @(negedge clk);
    end
    checks++;
    if (cnt4 !== 3'd0 || m4_valid !== 1'b0) begin
      failures++; $display("FAIL drain_empty: got c=%0d v=%b want 0/0", cnt4, m4_valid);
    end
  endtask

  task automatic test_streaming();
    int tx = 0;
    int rx = 0;
    do_reset();
    m4_ready = 1'b1;
    for (int c = 0; c < 100 && rx < 64; c++) begin
      checks++;
      if (cnt4 !== 3'(tx - rx)) begin
        failures++; $display("FAIL stream_count: got %0d want %0d", cnt4, tx - rx);
      end
      if (rx > 0 && rx < 64) begin
        checks++;
        if (m4_valid !== 1'b1) begin
          failures++; $display("FAIL stream_bubble: got v=0 want v=1 at beat %0d", rx);
        end
      end
      if (m4_valid) begin
        checks++;
        if (m4_data !== 8'(rx) || m4_last !== (rx == 63) ||
            m4_user !== 1'(rx & 1) || m4_keep !== 1'b1) begin
          failures++;
          $display("FAIL stream_beat_%0d: got d=%h l=%b u=%b k=%b want d=%h l=%b",
                   rx, m4_data, m4_last, m4_user, m4_keep, 8'(rx), rx == 63);
        end
        rx++;
      end
      s4_valid = (tx < 64);
      s4_data  = 8'(tx);
      s4_last  = (tx == 63);
      s4_user  = 1'(tx & 1);
      if (s4_valid && s4_ready) tx++;
      @(negedge clk);
    end
    s4_valid = 1'b0;
    checks++;
    if (rx !== 64) begin
      failures++; $display("FAIL stream_total: got %0d want 64", rx);
    end
  endtask

  task automatic test_flush();
    int n = 0;
    do_reset();
    m4_ready = 1'b0;
    push4(8'hB0);
    push4(8'hB1);
    push4(8'hB2);
    checks++;
    if (cnt4 !== 3'd3 || s4_ready !== 1'b1) begin
      failures++; $display("FAIL preflush: got c=%0d r=%b want 3/1", cnt4, s4_ready);
    end
    flush4   = 1'b1;
    s4_valid = 1'b1;
    s4_data  = 8'hEE;
    @(negedge clk);
    flush4   = 1'b0;
    s4_valid = 1'b0;
    checks++;
    if (m4_valid !== 1'b0 || cnt4 !== 3'd0 || s4_ready !== 1'b0 || af4 !== 1'b0) begin
      failures++;
      $display("FAIL flush_state: got v=%b c=%0d r=%b af=%b want 0/0/0/0",
               m4_valid, cnt4, s4_ready, af4);
    end
    @(negedge clk);
    checks++;
    if (s4_ready !== 1'b1) begin
      failures++; $display("FAIL flush_ready_back: got %b want 1", s4_ready);
    end
    m4_ready = 1'b1;
    push4(8'hC0);
    for (int i = 0; i < 5; i++) begin
      if (m4_valid) begin
        checks++;
        if (n != 0 || m4_data !== 8'hC0) begin
          failures++; $display("FAIL flush_output_%0d: got %h want only C0", n, m4_data);
        end
        n++;
      end
      @(negedge clk);
    end
    checks++;
    if (n !== 1) begin
      failures++; $display("FAIL flush_outputs: got %0d beats want 1", n);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    do_reset();
    m4_ready = 1'b0;
    push4(8'hE0);
    push4(8'hE1);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (m4_valid !== 1'b0 || s4_ready !== 1'b0 || cnt4 !== 3'd0) begin
      failures++;
      $display("FAIL async_reset: got v=%b r=%b c=%0d want 0/0/0",
               m4_valid, s4_ready, cnt4);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (s4_ready !== 1'b1) begin
      failures++; $display("FAIL async_release_ready: got %b want 1", s4_ready);
    end
    m4_ready = 1'b1;
    push4(8'hF0);
    for (int i = 0; i < 5; i++) begin
      if (m4_valid) begin
        checks++;
        if (n != 0 || m4_data !== 8'hF0) begin
          failures++; $display("FAIL async_output_%0d: got %h want only F0", n, m4_data);
        end
        n++;
      end
      @(negedge clk);
    end
    checks++;
    if (n !== 1) begin
      failures++; $display("FAIL async_outputs: got %0d beats want 1", n);
    end
  endtask

  // Queue model per instance; occupancy alone predicts count, valid,
  // ready and almost_full.
  task automatic test_random();
    logic [9:0] model [2][0:2047];
    int         head [2];
    int         tail [2];
    int         sent [2];
    int         rcvd [2];
    int         dep  [2];
    logic       stall[2];
    logic [9:0] held [2];
    logic [9:0] obs;
    logic [9:0] nw;
    logic [3:0] c;
    int         occ;
    dep[0] = 8;
    dep[1] = 2;
    for (int k = 0; k < 2; k++) begin
      head[k] = 0; tail[k] = 0; sent[k] = 0; rcvd[k] = 0;
      stall[k] = 1'b0; held[k] = '0;
    end
    do_reset();
    for (int cyc = 0; cyc < 8000 && (rcvd[0] < 1000 || rcvd[1] < 1000); cyc++) begin
      for (int k = 0; k < 2; k++) begin
        occ = tail[k] - head[k];
        c   = (k == 0) ? cnt8 : {2'b00, cnt2};
        obs = {r_muser[k], r_mlast[k], r_mdata[k]};
        checks++;
        if (c !== 4'(occ)) begin
          failures++; $display("FAIL rand_count d%0d: got %0d want %0d", dep[k], c, occ);
        end
        checks++;
        if (r_mvalid[k] !== (occ > 0)) begin
          failures++; $display("FAIL rand_valid d%0d: got %b want %b", dep[k], r_mvalid[k], occ > 0);
        end
        checks++;
        if (r_sready[k] !== (occ < dep[k])) begin
          failures++; $display("FAIL rand_ready d%0d: got %b want %b", dep[k], r_sready[k], occ < dep[k]);
        end
        checks++;
        if (r_af[k] !== (occ >= dep[k] - 1)) begin
          failures++; $display("FAIL rand_af d%0d: got %b want %b", dep[k], r_af[k], occ >= dep[k] - 1);
        end
        if (occ > 0) begin
          checks++;
          if (obs !== model[k][head[k]]) begin
            failures++;
            $display("FAIL rand_payload d%0d beat %0d: got %h want %h",
                     dep[k], rcvd[k], obs, model[k][head[k]]);
          end
        end
        if (stall[k]) begin
          checks++;
          if (obs !== held[k]) begin
            failures++; $display("FAIL rand_stable d%0d: got %h want %h", dep[k], obs, held[k]);
          end
        end
        nw          = 10'($urandom);
        r_mready[k] = 1'($urandom_range(0, 1));
        r_svalid[k] = (sent[k] < 1000) && ($urandom_range(0, 1) == 1);
        r_sdata[k]  = nw[7:0];
        r_slast[k]  = nw[8];
        r_suser[k]  = nw[9];
        stall[k]    = (occ > 0) && !r_mready[k];
        if (occ > 0) held[k] = model[k][head[k]];
        if (occ > 0 && r_mready[k]) begin
          head[k]++;
          rcvd[k]++;
        end
        if (r_svalid[k] && occ < dep[k]) begin
          model[k][tail[k]] = nw;
          tail[k]++;
          sent[k]++;
        end
      end
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      r_svalid[k] = 1'b0;
      checks++;
      if (rcvd[k] !== 1000) begin
        failures++; $display("FAIL rand_total d%0d: got %0d want 1000", dep[k], rcvd[k]);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_backpressure_fill();
    test_streaming();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
